slave_port: RTL

- Serial-bus slave endpoint sitting directly downstream of master_port.
- Deserialises the master's serial address, burst-size and write-data streams, then performs word writes or reads on a local memory.
- Returns read data serially to the master on rx_data, qualified by s_valid.
- One instance per slave; s_ready feeds the master's s_ready vector bit for this slave.

---
 rtl/slave_port.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/slave_port.sv
// Serial-bus slave endpoint: deserialises address/burst/write-data from the master,
// performs word accesses on a local memory and streams read data back LSB first.
module slave_port #(
  parameter int WORD_SIZE       = 8,
  parameter int SLAVE_ADDR_SIZE = 12,
  parameter int BURST_SIZE      = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_en,
  input  logic                       write_en,
  input  logic                       m_valid,
  input  logic                       addr_bus,
  input  logic                       burst_size_bus,
  input  logic                       w_data_bus,
  output logic                       s_ready,
  output logic                       s_valid,
  output logic                       rx_data,
  output logic                       done,
  output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic                       mem_we,
  output logic                       mem_re,
  input  logic [WORD_SIZE-1:0]       mem_rdata
);

  localparam int HDR_BITS = (SLAVE_ADDR_SIZE > BURST_SIZE) ? SLAVE_ADDR_SIZE : BURST_SIZE;
  localparam int HCW      = $clog2(HDR_BITS + 1);
  localparam int BCW      = $clog2(WORD_SIZE);

  typedef enum logic [2:0] {
    IDLE, HDR, WDATA, MWRITE, MREAD, MWAIT, RTX, FIN
  } state_t;

  state_t                     state;
  logic                       is_write;
  logic [HCW-1:0]             hdr_cnt;
  logic [BCW-1:0]             bit_cnt;
  logic [SLAVE_ADDR_SIZE-1:0] base_addr;
  logic [BURST_SIZE-1:0]      burst_len;
  logic [BURST_SIZE-1:0]      word_idx;
  logic [WORD_SIZE-1:0]       wdata_sr;
  logic [WORD_SIZE-1:0]       tx_sr;

  logic [SLAVE_ADDR_SIZE-1:0] base_next;
  logic [BURST_SIZE-1:0]      burst_next;
  logic [BURST_SIZE-1:0]      last_idx;
  logic [SLAVE_ADDR_SIZE-1:0] cur_addr;
  logic [SLAVE_ADDR_SIZE-1:0] nxt_addr;
  logic [WORD_SIZE-1:0]       wdata_next;
  logic                       hdr_last;
  logic                       bit_last;
  logic                       word_last;

  // Header fields shift in LSB first; a field narrower than the header stops
  // shifting once it is full so its first bit lands in bit 0.
  always_comb begin
    base_next  = base_addr;
    burst_next = burst_len;
    if (hdr_cnt < HCW'(SLAVE_ADDR_SIZE))
      base_next = {addr_bus, base_addr[SLAVE_ADDR_SIZE-1:1]};
    if (hdr_cnt < HCW'(BURST_SIZE))
      burst_next = {burst_size_bus, burst_len[BURST_SIZE-1:1]};
  end

  // A zero burst length behaves as a single-word burst.
  assign last_idx   = (burst_len == '0) ? '0 : burst_len - 1'b1;
  assign word_last  = (word_idx == last_idx);
  assign cur_addr   = base_addr + SLAVE_ADDR_SIZE'(word_idx);
  assign nxt_addr   = base_addr + SLAVE_ADDR_SIZE'(word_idx + 1'b1);
  assign wdata_next = {w_data_bus, wdata_sr[WORD_SIZE-1:1]};
  assign hdr_last   = (hdr_cnt == HCW'(HDR_BITS - 1));
  assign bit_last   = (bit_cnt == BCW'(WORD_SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      hdr_cnt   <= '0;
      bit_cnt   <= '0;
      base_addr <= '0;
      burst_len <= '0;
      word_idx  <= '0;
      wdata_sr  <= '0;
      tx_sr     <= '0;
      s_ready   <= 1'b1;
      s_valid   <= 1'b0;
      rx_data   <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid && (read_en ^ write_en)) begin
            is_write  <= write_en;
            base_addr <= base_next;
            burst_len <= burst_next;
            hdr_cnt   <= HCW'(1);
            word_idx  <= '0;
            bit_cnt   <= '0;
            s_ready   <= 1'b0;
            state     <= HDR;
          end
        end
        HDR: begin
          if (m_valid) begin
            base_addr <= base_next;
            burst_len <= burst_next;
            if (hdr_last) begin
              hdr_cnt <= '0;
              if (is_write) begin
                state <= WDATA;
              end else begin
                mem_re   <= 1'b1;
                mem_addr <= base_next;
                state    <= MREAD;
              end
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
            end
          end
        end
        WDATA: begin
          if (m_valid) begin
            wdata_sr <= wdata_next;
            if (bit_last) begin
              bit_cnt   <= '0;
              mem_we    <= 1'b1;
              mem_wdata <= wdata_next;
              mem_addr  <= cur_addr;
              state     <= MWRITE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        MWRITE: begin
          if (word_last) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= WDATA;
          end
        end
        MREAD: state <= MWAIT;
        MWAIT: begin
          tx_sr   <= mem_rdata;
          rx_data <= mem_rdata[0];
          s_valid <= 1'b1;
          bit_cnt <= '0;
          state   <= RTX;
        end
        RTX: begin
          if (bit_last) begin
            s_valid <= 1'b0;
            rx_data <= 1'b0;
            bit_cnt <= '0;
            if (word_last) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              word_idx <= word_idx + 1'b1;
              mem_re   <= 1'b1;
              mem_addr <= nxt_addr;
              state    <= MREAD;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx_sr   <= tx_sr >> 1;
            rx_data <= tx_sr[1];
          end
        end
        FIN: begin
          s_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
